// File: rtl/alu_seq_driver.sv
// ---------------------------------------------------------------------------
// alu_seq_driver
//
// Command-side initiator for the 16-bit ALU. It sits between the control unit
// and the ALU:
//   - It accepts one operation request at a time over a valid/ready command
//     channel.
//   - It drives the ALU's A, B, FunSel and WF pins for one pass (narrow) or
//     two chained passes (32-bit "wide").
//   - It returns the captured result and flags over a valid/ready response
//     channel.
//
// Ports
//   Clock, Reset          rising-edge clock, asynchronous active-high reset
//   CmdValid/CmdReady     command handshake
//   CmdFunSel             ALU function code
//   CmdWide               1 = 32-bit operation
//   CmdA, CmdB            operands; only [15:0] used when narrow
//   RspValid/RspReady     response handshake
//   RspData               result; [31:16] = 0 when narrow
//   RspFlags              {Z,C,N,O} in ALU flag order [3:0]
//   RspErr                command rejected (illegal wide code)
//   AluA, AluB            ALU operand pins
//   AluFunSel, AluWF      ALU function select and flag write enable
//   AluOut                ALU combinational result
//   AluFlags              ALU registered flags
//
// Optional feature (macro ALU_SEQ_STATS_EN)
//   Defined: adds OpCount/ErrCount outputs. They count completed response
//   handshakes and rejected ones, and wrap at 16 bits.
// ---------------------------------------------------------------------------
module alu_seq_driver #(
  parameter int          ALU_W      = 16,
  parameter logic [4:0]  ADD_FUNSEL = 5'b10100,
  parameter logic [4:0]  ADC_FUNSEL = 5'b10101
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 CmdValid,
  output logic                 CmdReady,
  input  logic [4:0]           CmdFunSel,
  input  logic                 CmdWide,
  input  logic [2*ALU_W-1:0]   CmdA,
  input  logic [2*ALU_W-1:0]   CmdB,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [2*ALU_W-1:0]   RspData,
  output logic [3:0]           RspFlags,
  output logic                 RspErr,
  output logic [ALU_W-1:0]     AluA,
  output logic [ALU_W-1:0]     AluB,
  output logic [4:0]           AluFunSel,
  output logic                 AluWF,
  input  logic [ALU_W-1:0]     AluOut,
  input  logic [3:0]           AluFlags
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]          OpCount,
  output logic [15:0]          ErrCount
`endif
);

  // Function code driven while no pass is in progress.
  localparam logic [4:0] FUN_IDLE = 5'b10000;

  typedef enum logic [2:0] {IDLE, LO, HI, FLG, RSP} state_t;

  state_t                state_q, state_d;
  logic [2*ALU_W-1:0]    a_q, a_d, b_q, b_d;
  logic [4:0]            fun_q, fun_d;
  logic                  wide_q, wide_d;
  logic [ALU_W-1:0]      res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [ALU_W-1:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2*ALU_W-1:0]    rsp_data_q, rsp_data_d;
  logic [3:0]            rsp_flags_q, rsp_flags_d;
  logic                  rsp_err_q, rsp_err_d;

  // Wide operations can only be split into two 16-bit passes for the
  // pass-through, bitwise and add codes. Subtract, 8-bit and shift codes
  // cannot be chained.
  function automatic logic wide_legal(input logic [4:0] f);
    return f[4] && (f != 5'b10110) && (f <= 5'b11010);
  endfunction

  // The handshake and ALU control pins are decoded straight from the state.
  // This makes AluWF drop the moment Reset forces the state back to IDLE.
  always_comb begin
    CmdReady  = (state_q == IDLE);
    RspValid  = (state_q == RSP);
    AluWF     = (state_q == LO) || (state_q == HI);
    AluFunSel = FUN_IDLE;
    if (state_q == LO) begin
      AluFunSel = fun_q;
    end else if (state_q == HI) begin
      // The high half of a wide add must absorb the low half's carry.
      AluFunSel = (fun_q == ADD_FUNSEL) ? ADC_FUNSEL : fun_q;
    end
  end

  assign AluA     = alu_a_q;
  assign AluB     = alu_b_q;
  assign RspData  = rsp_data_q;
  assign RspFlags = rsp_flags_q;
  assign RspErr   = rsp_err_q;

  // Next-state logic. AluA/AluB are registered and loaded on the edge that
  // enters LO or HI, so they hold their last values in the idle states.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    wide_d      = wide_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (CmdValid) begin
          a_d    = CmdA;
          b_d    = CmdB;
          fun_d  = CmdFunSel;
          wide_d = CmdWide;
          if (CmdWide && !wide_legal(CmdFunSel)) begin
            state_d     = RSP;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            rsp_flags_d = '0;
          end else begin
            state_d   = LO;
            rsp_err_d = 1'b0;
            alu_a_d   = CmdA[ALU_W-1:0];
            alu_b_d   = CmdB[ALU_W-1:0];
          end
        end
      end
      LO: begin
        res_lo_d = AluOut;
        if (wide_q) begin
          state_d = HI;
          alu_a_d = a_q[2*ALU_W-1:ALU_W];
          alu_b_d = b_q[2*ALU_W-1:ALU_W];
        end else begin
          state_d = FLG;
        end
      end
      HI: begin
        res_hi_d = AluOut;
        state_d  = FLG;
      end
      FLG: begin
        // The ALU's flag register now reflects the final pass. The ALU only
        // sees the high half, so Z is recomputed over the whole 32-bit result.
        rsp_flags_d = AluFlags;
        if (wide_q) begin
          rsp_flags_d[3] = (res_hi_q == '0) && (res_lo_q == '0);
          rsp_data_d     = {res_hi_q, res_lo_q};
        end else begin
          rsp_data_d     = {{ALU_W{1'b0}}, res_lo_q};
        end
        state_d = RSP;
      end
      RSP: begin
        if (RspReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      wide_q      <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      wide_q      <= wide_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count_q, op_count_d, err_count_q, err_count_d;

  // Both counters advance only on a completed response handshake and wrap
  // naturally at 16 bits.
  always_comb begin
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    if (RspValid && RspReady) begin
      op_count_d = op_count_q + 16'd1;
      if (rsp_err_q) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign OpCount  = op_count_q;
  assign ErrCount = err_count_q;
`endif

endmodule
